lector_bcd_2dig: RTL and testbench
==================================

Name: lector_bcd_2dig

Overview:
- Takes a 2-digit packed BCD byte (tens digit in [7:4], units digit in [3:0]) from the timekeeping data path, on a load strobe.
- Validates the byte, then converts it sequentially to a binary value in 0..MAX_VAL.
- Inverse of the binary-to-BCD hour/minute/second counter path: lets a BCD value read back from the clock source preload the binary counters.
- Reports completion with a one-cycle done pulse and an error flag.

Parameters:
- W, 5, width of the binary result. Must satisfy 2^W > MAX_VAL.
- MAX_VAL, 23, largest legal binary value. Use 23 for hours, 59 for minutes/seconds.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- carga  input  1  load strobe. Sampled only in IDLE.
- datos_bcd  input  8  packed BCD byte {digit1, digit0}.
- ocupado  output  1  high while a conversion is in progress.
- listo  output  1  one-cycle done pulse.
- error  output  1  result of the last accepted conversion was illegal.
- valor_bin  output  W  last legal converted value.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - ocupado=0, listo=0, error=0, valor_bin=0.
  - Internal byte, tens and flag registers are cleared.
- FSM states: IDLE, CHECK, CONV.
- IDLE:
  - If carga=1 at edge k: latch datos_bcd into byte_r, go to CHECK, ocupado=1 from edge k.
  - If carga=0: stay in IDLE.
- CHECK (edge k+1):
  - bad_digit <= (digit1>9) or (digit0>9).
  - tens_r (7 bits) <= digit1*10, computed as (digit1<<3)+(digit1<<1).
  - Go to CONV.
- CONV (edge k+2):
  - sum = tens_r + digit0, computed at 8-bit width with no truncation.
  - If bad_digit=1 or sum>MAX_VAL: error<=1, valor_bin unchanged.
  - Otherwise: error<=0, valor_bin<=sum[W-1:0].
  - In both cases listo<=1 for exactly one cycle, ocupado<=0, go to IDLE.
- Latency: carga sampled at edge k gives listo high during the cycle after edge k+2. Latency is fixed at 2 cycles for both legal and illegal input.
- carga while busy: ignored while ocupado=1 (CHECK, CONV). Not queued.
- carga in the listo cycle: the FSM is already in IDLE, so it is accepted. Back-to-back conversions run every 3 cycles.
- datos_bcd stability: only the value at the accepting edge matters. Later changes do not affect the result.
- error flag: held until the next CONV completes; an accepted load does not clear it. Error never modifies valor_bin.
- No wrap-around: illegal values are flagged, never reduced modulo MAX_VAL+1.
- Reset mid-operation: reset in CHECK or CONV aborts immediately to the reset values. No listo pulse is produced for the aborted conversion.
- Outputs: all outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- MAX_VAL=23, reset then datos_bcd=8'h23, carga one cycle at edge k → ocupado=1 from k to k+2; listo pulses one cycle after edge k+2; valor_bin=23, error=0.
- After the previous case, datos_bcd=8'h24 → listo pulses, error=1, valor_bin stays 23. Then 8'h00 → error=0, valor_bin=0.
- datos_bcd=8'h1A, then 8'hA1 → each gives listo with error=1 (illegal digit), same 2-cycle latency, valor_bin unchanged.
- Load 8'h15, assert carga again with 8'h09 on the next cycle → second load ignored; valor_bin=15. Then carga in the listo cycle with 8'h09 → accepted; valor_bin=9 three cycles later.
- Load 8'h12, assert reset at edge k+1 → no listo pulse; all outputs 0; FSM returns to IDLE. A following load of 8'h07 → valor_bin=7.
- W=6, MAX_VAL=59: 8'h59 → valor_bin=59, error=0. 8'h60 → error=1. 8'h99 → error=1 (sum=99, 8-bit compare, no truncation).

Source files
------------

// File: rtl/lector_bcd_2dig_if.sv
// Load/result bundle for the 2-digit BCD-to-binary reader.
// master drives the load side, slave is the converter.
interface lector_bcd_2dig_if #(
  parameter int W = 5
);
  logic         carga;
  logic [7:0]   datos_bcd;
  logic         ocupado;
  logic         listo;
  logic         error;
  logic [W-1:0] valor_bin;

  modport master (
    output carga, datos_bcd,
    input  ocupado, listo, error, valor_bin
  );

  modport slave (
    input  carga, datos_bcd,
    output ocupado, listo, error, valor_bin
  );
endinterface

// File: rtl/lector_bcd_2dig.sv
// Sequential 2-digit packed BCD to binary converter with range check.
// A load is latched in IDLE, digits are checked and the tens product is
// formed in CHECK, and the sum is range-checked and committed in CONV.
// An illegal byte raises error and leaves the previous value in place.
module lector_bcd_2dig #(
  parameter int W       = 5,
  parameter int MAX_VAL = 23
) (
  input logic              clk,
  input logic              reset,
  lector_bcd_2dig_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CONV  = 2'd2
  } state_t;

  localparam logic [7:0] MAX8 = 8'(MAX_VAL);

  state_t       state;
  logic [7:0]   byte_r;
  logic [6:0]   tens_r;
  logic         bad_digit;
  logic         ocupado_r;
  logic         listo_r;
  logic         error_r;
  logic [W-1:0] valor_r;

  logic [3:0]   d1, d0;
  logic [6:0]   d1_x;
  logic [6:0]   tens_nx;
  logic [7:0]   sum;

  assign d1   = byte_r[7:4];
  assign d0   = byte_r[3:0];
  assign d1_x = {3'b000, d1};
  // digit1*10 without a multiplier; an illegal tens digit can overflow
  // 7 bits, but that case is already flagged through bad_digit
  assign tens_nx = (d1_x << 3) + (d1_x << 1);
  // 8-bit sum so out-of-range results (up to 99) are never truncated
  assign sum = {1'b0, tens_r} + {4'b0000, d0};

  // Control FSM; every output is a register updated here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      byte_r    <= '0;
      tens_r    <= '0;
      bad_digit <= 1'b0;
      ocupado_r <= 1'b0;
      listo_r   <= 1'b0;
      error_r   <= 1'b0;
      valor_r   <= '0;
    end else begin
      listo_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.carga) begin
            byte_r    <= bus.datos_bcd;
            ocupado_r <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          bad_digit <= (d1 > 4'd9) || (d0 > 4'd9);
          tens_r    <= tens_nx;
          state     <= CONV;
        end
        CONV: begin
          if (bad_digit || (sum > MAX8)) begin
            error_r <= 1'b1;
          end else begin
            error_r <= 1'b0;
            valor_r <= sum[W-1:0];
          end
          listo_r   <= 1'b1;
          ocupado_r <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          ocupado_r <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ocupado   = ocupado_r;
  assign bus.listo     = listo_r;
  assign bus.error     = error_r;
  assign bus.valor_bin = valor_r;

endmodule

// File: tb/tb_lector_bcd_2dig.sv
// Bench for lector_bcd_2dig: an hours instance (W=5, MAX_VAL=23) and a
// minutes instance (W=6, MAX_VAL=59) driven with the same load stream.
module tb_lector_bcd_2dig;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  lector_bcd_2dig_if #(.W(5)) bus_a ();
  lector_bcd_2dig_if #(.W(6)) bus_b ();

  lector_bcd_2dig #(.W(5), .MAX_VAL(23)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  lector_bcd_2dig #(.W(6), .MAX_VAL(59)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    int         err_a;
    int         val_a;
    int         err_b;
    int         val_b;
  } vec_t;

  vec_t vecs[10];

  // reference state for the random phase
  int mval_a, merr_a, mval_b, merr_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic c, input logic [7:0] d);
    bus_a.carga     = c;
    bus_b.carga     = c;
    bus_a.datos_bcd = d;
    bus_b.datos_bcd = d;
  endtask

  task automatic chk_both(input string name, input int oc, input int li);
    chk({name, " ocupado_a"}, int'(bus_a.ocupado), oc);
    chk({name, " ocupado_b"}, int'(bus_b.ocupado), oc);
    chk({name, " listo_a"},   int'(bus_a.listo),   li);
    chk({name, " listo_b"},   int'(bus_b.listo),   li);
  endtask

  task automatic chk_res(input string name, input int ea, input int va,
                         input int eb, input int vb);
    chk({name, " error_a"}, int'(bus_a.error),     ea);
    chk({name, " valor_a"}, int'(bus_a.valor_bin), va);
    chk({name, " error_b"}, int'(bus_b.error),     eb);
    chk({name, " valor_b"}, int'(bus_b.valor_bin), vb);
  endtask

  // One full conversion: load at edge k, result seen after edge k+2
  task automatic do_conv(input logic [7:0] d, input int ea, input int va,
                         input int eb, input int vb, input string tag);
    @(negedge clk); drv(1'b1, d);
    @(posedge clk); #1; chk_both({tag, " k"}, 1, 0);
    @(negedge clk); drv(1'b0, 8'($urandom));   // later data must not matter
    @(posedge clk); #1; chk_both({tag, " k+1"}, 1, 0);
    @(posedge clk); #1; chk_both({tag, " k+2"}, 0, 1);
    chk_res(tag, ea, va, eb, vb);
    @(posedge clk); #1; chk_both({tag, " k+3"}, 0, 0);
  endtask

  // Behavioural reference: decimal value from the two nibbles
  function automatic void ref_conv(input logic [7:0] d, input int maxv,
                                   inout int val, inout int err);
    int hi, lo, v;
    hi = int'(d[7:4]);
    lo = int'(d[3:0]);
    v  = hi * 10 + lo;
    if (hi > 9 || lo > 9 || v > maxv) err = 1;
    else begin
      err = 0;
      val = v;
    end
  endfunction

  initial begin
    vecs[0] = '{8'h23, 0, 23, 0, 23};
    vecs[1] = '{8'h24, 1, 23, 0, 24};
    vecs[2] = '{8'h00, 0, 0,  0, 0};
    vecs[3] = '{8'h1A, 1, 0,  1, 0};
    vecs[4] = '{8'hA1, 1, 0,  1, 0};
    vecs[5] = '{8'h59, 1, 0,  0, 59};
    vecs[6] = '{8'h60, 1, 0,  1, 59};
    vecs[7] = '{8'h99, 1, 0,  1, 59};
    vecs[8] = '{8'h07, 0, 7,  0, 7};
    vecs[9] = '{8'hFF, 1, 7,  1, 7};

    drv(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk_both("reset", 0, 0);
    chk_res("reset", 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk_both("idle", 0, 0);

    foreach (vecs[i])
      do_conv(vecs[i].d, vecs[i].err_a, vecs[i].val_a,
              vecs[i].err_b, vecs[i].val_b, $sformatf("vec%0d", i));

    // load while busy is ignored; load in the listo cycle is accepted
    @(negedge clk); drv(1'b1, 8'h15);
    @(posedge clk); #1; chk_both("busy k", 1, 0);
    @(negedge clk); drv(1'b1, 8'h09);
    @(posedge clk); #1; chk_both("busy k+1", 1, 0);
    @(negedge clk); drv(1'b0, 8'h00);
    @(posedge clk); #1; chk_both("busy k+2", 0, 1);
    chk_res("busy", 0, 15, 0, 15);
    @(negedge clk); drv(1'b1, 8'h09);
    @(posedge clk); #1; chk_both("b2b k", 1, 0);
    @(negedge clk); drv(1'b0, 8'h00);
    @(posedge clk); #1; chk_both("b2b k+1", 1, 0);
    @(posedge clk); #1; chk_both("b2b k+2", 0, 1);
    chk_res("b2b", 0, 9, 0, 9);
    @(posedge clk); #1; chk_both("b2b k+3", 0, 0);

    // reset mid-conversion aborts with no done pulse
    @(negedge clk); drv(1'b1, 8'h12);
    @(posedge clk); #1; chk_both("abort k", 1, 0);
    @(negedge clk); drv(1'b0, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk_both("abort async", 0, 0);
    chk_res("abort async", 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_both($sformatf("abort idle%0d", i), 0, 0);
    end
    do_conv(8'h07, 0, 7, 0, 7, "after abort");

    // randomized loads against the reference model
    mval_a = 7; merr_a = 0; mval_b = 7; merr_b = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) d = 8'($urandom);
      else d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ref_conv(d, 23, mval_a, merr_a);
      ref_conv(d, 59, mval_b, merr_b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_conv(d, merr_a, mval_a, merr_b, mval_b, $sformatf("rnd%0d d=%h", n, d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
